countdown_timer_ctrl: RTL and testbench
=======================================

# countdown_timer_ctrl

Command-driven countdown timer controller that sequences a loadable up/down counter through load, run, pause and expire phases. Sits between software/handshake logic and the counter datapath. Converts start/pause/resume/abort commands plus a programmed duration into counter load/enable/direction control, and produces a one-cycle `expired` pulse. Used as the timing engine for interval, timeout and stopwatch-style functions.

## Interface
- `WIDTH`, 8: width of duration and remaining count.
- `PRESCALE`, 4: clock cycles per count tick; legal range is 1 to 2^16.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin countdown from `duration`; honoured only in IDLE.
- `pause`  in  1  freeze countdown; honoured only in RUN.
- `resume`  in  1  continue countdown; honoured only in PAUSE.
- `abort`  in  1  cancel from any non-IDLE state.
- `duration`  in  WIDTH  tick count, latched on an accepted `start`.
- `auto_reload`  in  1  restart after expiry; used only when the reload feature is compiled in.
- `remaining`  out  WIDTH  current count value.
- `busy`  out  1  high in LOAD, RUN, PAUSE and DONE.
- `paused`  out  1  high in PAUSE.
- `expired`  out  1  one-cycle pulse on reaching 0.

## Operation
- States are IDLE, LOAD, RUN, PAUSE and DONE. All outputs are registered.
- **Command priority:** abort > pause > resume > start. Commands that are illegal in the current state are ignored with no side effects.
- **IDLE**
  - `start` with `duration` != 0: latch `duration` into `dur_q`, go to LOAD.
  - `start` with `duration` == 0: pulse `expired` next cycle, stay in IDLE, `remaining` = 0.
- **LOAD** (one cycle): `remaining` <= `dur_q`, prescaler cleared, go to RUN.
- **RUN**
  - Prescaler counts 0 to PRESCALE-1. At PRESCALE-1 a tick fires and `remaining` decrements by 1.
  - Tick while `remaining` == 1: `remaining` <= 0, `expired` <= 1, go to DONE.
  - `pause`: go to PAUSE. The prescaler value is held, not cleared.
  - `abort`: go to IDLE, `remaining` <= 0, no `expired`.
  - `pause` on the same cycle as a tick: the tick's decrement still commits, then go to PAUSE.
- **PAUSE**
  - `resume`: go to RUN; the prescaler continues from its held value.
  - `abort`: go to IDLE with `remaining` <= 0.
- **DONE** (one cycle): go to IDLE, unless the reload path applies (see Configuration).
- **Counter rules:** `remaining` never wraps. Decrement below 0 is impossible by construction, and the count direction is always down.
- **Reset mid-operation:** asynchronous return to IDLE with every output at 0 and the latched duration cleared.

## Timing
- **Reset values:** `remaining`=0, `busy`=0, `paused`=0, `expired`=0, state IDLE, prescaler 0, `dur_q`=0.
- **Start sequence:** `start` sampled at edge 0 gives LOAD after edge 0. After edge 1, `remaining`=D.
- **Decrement timing:** decrements land at edges 1+k·PRESCALE, for k=1..D.
- **Expiry:** `expired` is high for exactly the one cycle after edge 1+D·PRESCALE, coincident with `remaining`=0 and state DONE.
- **Start-to-expiry latency:** D·PRESCALE+1 cycles from the edge that accepts `start` to the `expired` cycle. Example: D=3, P=4 gives expired after edge 13.
- **Pause effect:** each cycle spent in PAUSE extends expiry by exactly one cycle.
- **Status outputs:** `busy` goes high the cycle after an accepted `start` and falls the cycle after DONE.
- **Back-to-back use:** `start` is accepted again on the first IDLE cycle.

## Configuration
- **Macro:** `TIMER_AUTO_RELOAD_EN`.
- **Defined:** in DONE, if `auto_reload`=1, go to LOAD instead of IDLE.
  - `dur_q` is reused, so expiries repeat every D·PRESCALE+2 cycles.
  - `busy` stays high throughout.
  - `abort` in any phase stops the sequence.
- **Undefined:** `auto_reload` is ignored and DONE always goes to IDLE. The port remains present, so the netlist interface is identical in both builds.

## Structure
- **Shared package `timer_pkg`:** the `timer_state_e` enum (IDLE, LOAD, RUN, PAUSE, DONE) and the prescaler width constant, `$clog2(PRESCALE)` with a minimum of 1.
- **Sub-module:** one, `updown_counter_core`, the WIDTH-bit loadable counter with load, enable and direction inputs.
  - This controller drives it with `load` = LOAD state, `enable` = RUN and tick, `direction` = 0.
  - Prescaler and FSM stay in this module.

## Test plan
- **Basic expiry:** D=3, P=4, `start` at edge 0 → `remaining` reads 3,2,1,0 at edges 1,5,9,13; `expired` high only after edge 13; `busy` low after edge 14.
- **Pause/resume:** D=5, P=4, `pause` 6 cycles after LOAD, held 10 cycles, then `resume` → expiry exactly 10 cycles later than baseline; `paused`=1 during the hold; `remaining` frozen at 4.
- **Abort:** D=10 with `abort` mid-RUN → next cycle IDLE, `remaining`=0, `busy`=0, no `expired` pulse ever.
- **Zero and ignored commands:**
  - D=0 `start` → `expired` pulse next cycle, `busy` never asserts.
  - `start` during RUN has no effect on `remaining` or `dur_q`.
- **Simultaneous events:**
  - `abort`+`pause` together → IDLE.
  - `pause` on a tick cycle → decrement commits, then PAUSE.
  - `rst_n` low mid-RUN → all outputs 0 asynchronously.
- **Auto-reload (`TIMER_AUTO_RELOAD_EN`):** D=2, P=1, `auto_reload`=1 → `expired` pulses every 4 cycles; clearing `auto_reload` stops it after the current expiry.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and sizing helpers for countdown_timer_ctrl and its counter core.
package timer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      PAUSE,
      DONE
   } timer_state_e;

   // Prescaler counts 0..p-1, so it needs clog2(p) bits, with at least one bit.
   function automatic int unsigned presc_width(input int unsigned p);
      return (p <= 2) ? 1 : $clog2(p);
   endfunction

   localparam int unsigned PRESC_W_DEFAULT = presc_width(4);

endpackage

// File: rtl/updown_counter_core.sv
// Loadable, saturating up/down counter: load has priority over enable.
import timer_pkg::*;

module updown_counter_core #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             enable_i,
   input  logic             dir_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (enable_i) begin
         // Saturate at both ends so the count never wraps.
         if (dir_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
         end else if (!dir_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Command-driven countdown timer FSM with prescaler; drives updown_counter_core.
// Optional restart-after-expiry is compiled in with `define TIMER_AUTO_RELOAD_EN.
import timer_pkg::*;

module countdown_timer_ctrl #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             pause,
   input  logic             resume,
   input  logic             abort,
   input  logic [WIDTH-1:0] duration,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] remaining,
   output logic             busy,
   output logic             paused,
   output logic             expired
);

   localparam int unsigned    PW        = presc_width(PRESCALE);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);

   timer_state_e     state_q, state_d;
   logic [WIDTH-1:0] dur_q, dur_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             expired_q, expired_d;
   logic             busy_q, paused_q;
   logic             tick;
   logic             cnt_load, cnt_en;
   logic [WIDTH-1:0] cnt_load_val;

`ifndef TIMER_AUTO_RELOAD_EN
   logic unused_auto_reload;
   assign unused_auto_reload = auto_reload;
`endif

   assign tick = (presc_q == PRESC_MAX);

   always_comb begin
      state_d      = state_q;
      dur_d        = dur_q;
      presc_d      = presc_q;
      expired_d    = 1'b0;
      cnt_load     = 1'b0;
      cnt_en       = 1'b0;
      cnt_load_val = dur_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (duration != '0) begin
                  dur_d   = duration;
                  state_d = LOAD;
               end else begin
                  expired_d = 1'b1;
               end
            end
         end
         LOAD: begin
            cnt_load = 1'b1;
            presc_d  = '0;
            if (abort) begin
               cnt_load_val = '0;
               state_d      = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               cnt_load     = 1'b1;
               cnt_load_val = '0;
               presc_d      = '0;
               state_d      = IDLE;
            end else begin
               // The prescaler advances on the pause cycle too, so a tick there still commits.
               presc_d = tick ? '0 : presc_q + 1'b1;
               cnt_en  = tick;
               if (tick && (remaining == WIDTH'(1))) begin
                  expired_d = 1'b1;
                  state_d   = DONE;
               end else if (pause) begin
                  state_d = PAUSE;
               end
            end
         end
         PAUSE: begin
            if (abort) begin
               cnt_load     = 1'b1;
               cnt_load_val = '0;
               presc_d      = '0;
               state_d      = IDLE;
            end else if (resume) begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
`ifdef TIMER_AUTO_RELOAD_EN
            if (!abort && auto_reload) begin
               state_d = LOAD;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dur_q     <= '0;
         presc_q   <= '0;
         expired_q <= 1'b0;
         busy_q    <= 1'b0;
         paused_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         dur_q     <= dur_d;
         presc_q   <= presc_d;
         expired_q <= expired_d;
         busy_q    <= (state_d != IDLE);
         paused_q  <= (state_d == PAUSE);
      end
   end

   updown_counter_core #(
      .WIDTH(WIDTH)
   ) u_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (cnt_load),
      .enable_i  (cnt_en),
      .dir_i     (1'b0),
      .load_val_i(cnt_load_val),
      .count_o   (remaining)
   );

   assign busy    = busy_q;
   assign paused  = paused_q;
   assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed self-checking bench for countdown_timer_ctrl (WIDTH=8, PRESCALE=4).
module tb_countdown_timer_ctrl;

   localparam int unsigned W = 8;
   localparam int unsigned P = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, pause, resume, abort, auto_reload;
   logic [W-1:0] duration;
   logic [W-1:0] remaining;
   logic         busy, paused, expired;

   int n_cmp = 0;
   int n_err = 0;
   int edge_n;
   int pulses;

   countdown_timer_ctrl #(
      .WIDTH   (W),
      .PRESCALE(P)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .pause      (pause),
      .resume     (resume),
      .abort      (abort),
      .duration   (duration),
      .auto_reload(auto_reload),
      .remaining  (remaining),
      .busy       (busy),
      .paused     (paused),
      .expired    (expired)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic chk_out(input string tag, input int rem, input int bsy, input int pau, input int exp);
      chk({tag, ".remaining"}, 32'(remaining), 32'(rem));
      chk({tag, ".busy"},      32'(busy),      32'(bsy));
      chk({tag, ".paused"},    32'(paused),    32'(pau));
      chk({tag, ".expired"},   32'(expired),   32'(exp));
   endtask

   task automatic do_start(input logic [W-1:0] d);
      duration = d;
      start    = 1'b1;
      edge_n   = -1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 0; pause = 0; resume = 0; abort = 0; auto_reload = 0;
      duration = '0; edge_n = 0;

      #3;
      chk_out("reset", 0, 0, 0, 0);
      chk("reset.dur_q", 32'(dut.dur_q), 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      step();

`ifndef TIMER_AUTO_RELOAD_EN
      // Basic expiry: D=3 -> 3,2,1,0 after edges 1,5,9,13; expired only after 13.
      do_start(8'd3);
      chk_out("basic.load", 0, 1, 0, 0);
      for (int e = 1; e <= 14; e++) begin
         int rem;
         step();
         rem = (e >= 13) ? 0 : 3 - (e - 1) / 4;
         chk_out("basic", rem, (e <= 13) ? 1 : 0, 0, (e == 13) ? 1 : 0);
      end

      // Pause after edge 7 for 10 cycles; expiry moves from edge 21 to 31.
      do_start(8'd5);
      while (edge_n < 6) step();
      pause = 1'b1;
      step();
      pause = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk_out("pause.hold", 4, 1, 1, 0);
         if (i < 9) step();
      end
      resume = 1'b1;
      step();
      resume = 1'b0;
      chk_out("pause.resumed", 4, 1, 0, 0);
      pulses = 0;
      while (edge_n < 30) begin
         step();
         if (expired) pulses++;
      end
      chk("pause.no_early_expiry", 32'(pulses), 0);
      chk("pause.rem_before", 32'(remaining), 1);
      step();
      chk_out("pause.expiry", 0, 1, 0, 1);
      step();
      chk_out("pause.idle", 0, 0, 0, 0);

      // Abort mid-RUN: straight to IDLE, no expiry pulse afterwards.
      do_start(8'd10);
      while (edge_n < 6) step();
      chk("abort.rem_before", 32'(remaining), 9);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk_out("abort", 0, 0, 0, 0);
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (expired || busy) pulses++;
      end
      chk("abort.quiet", 32'(pulses), 0);

      // Zero duration start, then illegal commands in IDLE.
      do_start(8'd0);
      chk_out("zero.pulse", 0, 0, 0, 1);
      step();
      chk_out("zero.after", 0, 0, 0, 0);
      pause = 1'b1; resume = 1'b1; abort = 1'b1;
      step();
      pause = 1'b0; resume = 1'b0; abort = 1'b0;
      chk_out("idle.ignore", 0, 0, 0, 0);

      // Start during RUN is ignored; timing and latched duration unchanged.
      do_start(8'd3);
      step(); step();
      duration = 8'd7;
      start    = 1'b1;
      step();
      start = 1'b0;
      chk("runstart.rem", 32'(remaining), 3);
      chk("runstart.dur_q", 32'(dut.dur_q), 3);
      while (edge_n < 12) step();
      chk("runstart.not_yet", 32'(expired), 0);
      step();
      chk_out("runstart.expiry", 0, 1, 0, 1);
      step();
      chk_out("runstart.idle", 0, 0, 0, 0);

      // Back-to-back: accepted on the first IDLE cycle; D=1 expires after edge 5.
      do_start(8'd1);
      chk_out("b2b.load", 0, 1, 0, 0);
      step();
      chk("b2b.rem", 32'(remaining), 1);
      while (edge_n < 4) step();
      chk("b2b.not_yet", 32'(expired), 0);
      step();
      chk_out("b2b.expiry", 0, 1, 0, 1);
      step();

      // Abort and pause together in RUN: abort wins.
      do_start(8'd4);
      while (edge_n < 3) step();
      abort = 1'b1; pause = 1'b1;
      step();
      abort = 1'b0; pause = 1'b0;
      chk_out("abort_pause", 0, 0, 0, 0);

      // Pause on the tick edge 5: decrement commits, then hold, then abort from PAUSE.
      do_start(8'd3);
      while (edge_n < 4) step();
      chk("ptick.rem_before", 32'(remaining), 3);
      pause = 1'b1;
      step();
      pause = 1'b0;
      chk_out("ptick.paused", 2, 1, 1, 0);
      step(); step(); step();
      chk_out("ptick.held", 2, 1, 1, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk_out("ptick.abort", 0, 0, 0, 0);

      // Asynchronous reset mid-RUN.
      do_start(8'd8);
      while (edge_n < 5) step();
      chk("areset.rem_before", 32'(remaining), 7);
      #2 rst_n = 1'b0;
      #1;
      chk_out("areset", 0, 0, 0, 0);
      chk("areset.dur_q", 32'(dut.dur_q), 0);
      #1 rst_n = 1'b1;
      step(); step();
      chk_out("areset.after", 0, 0, 0, 0);
`else
      // Auto-reload, D=2, P=4: expiries every 10 cycles at edges 9, 19, 29.
      auto_reload = 1'b1;
      do_start(8'd2);
      for (int e = 1; e <= 40; e++) begin
         step();
         if (e == 20) auto_reload = 1'b0;
         chk("reload.expired", 32'(expired), (e == 9 || e == 19 || e == 29) ? 1 : 0);
         chk("reload.busy", 32'(busy), (e <= 29) ? 1 : 0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
